// File: rtl/refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : refill_pkg
//  Description : Shared types and default constants for the cache refill
//                engine: FSM state encoding and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package refill_pkg;

    // Default geometry: 32-bit byte addresses, 32-bit words, 4-word lines
    localparam int c_def_addr_width     = 32;
    localparam int c_def_data_width     = 32;
    localparam int c_def_words_per_line = 4;

    // Refill FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FILL    = 3'd4
    } refill_state_t;

endpackage : refill_pkg
`default_nettype wire

// File: rtl/cache_refill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_engine
//  Description : Services one cache miss at a time. An optional dirty victim
//                line is written back word by word, then the missing line is
//                read word by word into a line buffer and presented to the
//                cache. Talks to memory through a single-beat request /
//                response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_engine
    import refill_pkg::*;
#(
    parameter int ADDR_WIDTH     = c_def_addr_width,
    parameter int DATA_WIDTH     = c_def_data_width,
    parameter int WORDS_PER_LINE = c_def_words_per_line
) (
    input  logic                               clk,
    input  logic                               rst_n,
    // Miss request from the cache
    input  logic                               miss_valid,
    output logic                               miss_ready,
    input  logic [ADDR_WIDTH-1:0]              miss_addr,
    input  logic                               miss_dirty,
    input  logic [ADDR_WIDTH-1:0]              victim_addr,
    input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] victim_data,
    // Filled line back to the cache
    output logic                               fill_valid,
    input  logic                               fill_ready,
    output logic [ADDR_WIDTH-1:0]              fill_addr,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] fill_data,
    // Single-beat memory request
    output logic                               req_valid,
    input  logic                               req_ready,
    output logic                               req_is_write,
    output logic [ADDR_WIDTH-1:0]              req_addr,
    output logic [DATA_WIDTH-1:0]              req_wdata,
    output logic [DATA_WIDTH/8-1:0]            req_wstrb,
    // Read response
    input  logic                               resp_valid,
    output logic                               resp_ready,
    input  logic [DATA_WIDTH-1:0]              resp_rdata,
    // Status
    output logic                               busy
);

    localparam int c_beat_w    = $clog2(WORDS_PER_LINE);
    localparam int c_byte_sh   = $clog2(DATA_WIDTH / 8);
    localparam int c_line_off  = $clog2(WORDS_PER_LINE * (DATA_WIDTH / 8));
    localparam int c_line_w    = WORDS_PER_LINE * DATA_WIDTH;

    localparam logic [c_beat_w-1:0]   c_last_beat = c_beat_w'(WORDS_PER_LINE - 1);
    localparam logic [c_beat_w-1:0]   c_beat_one  = c_beat_w'(1);
    // Clears the byte-within-line bits of an address
    localparam logic [ADDR_WIDTH-1:0] c_line_mask =
        ~((ADDR_WIDTH'(1) << c_line_off) - ADDR_WIDTH'(1));

    refill_state_t              r_state;
    logic [c_beat_w-1:0]        r_beat;
    logic [ADDR_WIDTH-1:0]      r_fill_base;
    logic [ADDR_WIDTH-1:0]      r_victim_base;
    logic [c_line_w-1:0]        r_victim_data;
    logic [c_line_w-1:0]        r_line;

    logic                       w_last_beat;
    logic [ADDR_WIDTH-1:0]      w_beat_off;

    assign w_last_beat = (r_beat == c_last_beat);
    assign w_beat_off  = ADDR_WIDTH'(r_beat) << c_byte_sh;

    // Refill sequencing: capture the miss, write back the victim, read the
    // new line beat by beat, then hold it until the cache takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_beat        <= '0;
            r_fill_base   <= '0;
            r_victim_base <= '0;
            r_victim_data <= '0;
            r_line        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (miss_valid) begin
                        r_fill_base   <= miss_addr & c_line_mask;
                        r_victim_base <= victim_addr & c_line_mask;
                        r_victim_data <= victim_data;
                        r_beat        <= '0;
                        r_state       <= miss_dirty ? ST_WB_REQ : ST_RD_REQ;
                    end
                end
                ST_WB_REQ: begin
                    // Writes are posted: each accepted beat moves straight on
                    if (req_ready) begin
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= ST_RD_REQ;
                        end else begin
                            r_beat  <= r_beat + c_beat_one;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (req_ready) begin
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (resp_valid) begin
                        r_line[r_beat*DATA_WIDTH +: DATA_WIDTH] <= resp_rdata;
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= ST_FILL;
                        end else begin
                            r_beat  <= r_beat + c_beat_one;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_FILL: begin
                    if (fill_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode: everything depends only on registered state, so request
    // fields hold steady while the downstream stalls
    always_comb begin
        miss_ready   = 1'b0;
        busy         = 1'b1;
        req_valid    = 1'b0;
        req_is_write = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wstrb    = '0;
        resp_ready   = 1'b0;
        fill_valid   = 1'b0;
        fill_addr    = '0;
        fill_data    = '0;
        case (r_state)
            ST_IDLE: begin
                miss_ready = 1'b1;
                busy       = 1'b0;
            end
            ST_WB_REQ: begin
                req_valid    = 1'b1;
                req_is_write = 1'b1;
                req_addr     = r_victim_base + w_beat_off;
                req_wdata    = r_victim_data[r_beat*DATA_WIDTH +: DATA_WIDTH];
                req_wstrb    = '1;
            end
            ST_RD_REQ: begin
                req_valid = 1'b1;
                req_addr  = r_fill_base + w_beat_off;
            end
            ST_RD_WAIT: begin
                resp_ready = 1'b1;
            end
            ST_FILL: begin
                fill_valid = 1'b1;
                fill_addr  = r_fill_base;
                fill_data  = r_line;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule : cache_refill_engine
`default_nettype wire

// File: doc/cache_refill_engine.md
CACHE_REFILL_ENGINE -- requirements
Module: cache_refill_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; power of two, >= 8.
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4, words per cache line; power of two, >= 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-005 Ports SHALL be:
clk  in  1  clock
rst_n  in  1  async active-low reset
miss_valid  in  1  cache miss request
miss_ready  out  1  engine accepts miss
miss_addr  in  ADDR_WIDTH  address to fill; low line-offset bits ignored
miss_dirty  in  1  victim must be written back first
victim_addr  in  ADDR_WIDTH  victim line address; low line-offset bits ignored
victim_data  in  WORDS_PER_LINE*DATA_WIDTH  victim line; word 0 in LSBs
fill_valid  out  1  filled line available
fill_ready  in  1  cache takes line
fill_addr  out  ADDR_WIDTH  line-aligned fill address
fill_data  out  WORDS_PER_LINE*DATA_WIDTH  filled line; word 0 in LSBs
req_valid  out  1  single-beat memory request
req_ready  in  1  downstream accepts request
req_is_write  out  1  1=write, 0=read
req_addr  out  ADDR_WIDTH  word byte address
req_wdata  out  DATA_WIDTH  write word
req_wstrb  out  DATA_WIDTH/8  byte strobes
resp_valid  in  1  read data valid
resp_ready  out  1  engine accepts read data
resp_rdata  in  DATA_WIDTH  read word
busy  out  1  high in any state except IDLE

Function
REQ-006 FSM states SHALL be: IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL.
REQ-007 miss_ready SHALL equal (state==IDLE); a miss is accepted on miss_valid&&miss_ready.
REQ-008 On acceptance, miss_addr, miss_dirty, victim_addr and victim_data SHALL be captured, with line-offset bits forced to zero. The beat counter SHALL be cleared. The next state SHALL be WB_REQ if miss_dirty is high, otherwise RD_REQ.
REQ-009 In WB_REQ, outputs SHALL be: req_valid=1, req_is_write=1, req_addr=victim_base+beat*(DATA_WIDTH/8), req_wdata=captured victim word[beat], req_wstrb all ones.
REQ-010 In WB_REQ, a beat SHALL complete on req_valid&&req_ready. On the last beat the FSM SHALL go to RD_REQ with beat=0; otherwise beat SHALL increment.
REQ-011 No write response is awaited. The next request SHALL be issued only when req_ready is seen high again.
REQ-012 In RD_REQ, outputs SHALL be: req_valid=1, req_is_write=0, req_addr=fill_base+beat*(DATA_WIDTH/8), req_wstrb=0. The FSM SHALL go to RD_WAIT on req_ready.
REQ-013 In RD_WAIT, resp_ready SHALL be 1. On resp_valid, resp_rdata SHALL be written to line buffer word[beat]. Then the FSM SHALL go to FILL if beat is last, otherwise increment beat and go to RD_REQ.
REQ-014 In FILL, fill_valid SHALL be 1 with stable fill_addr and fill_data. The FSM SHALL go to IDLE on fill_ready.
REQ-015 req_valid SHALL be 0 and request fields SHALL be 0 outside WB_REQ and RD_REQ. resp_ready SHALL be 0 outside RD_WAIT.
REQ-016 Request fields SHALL stay stable while req_valid is high and req_ready is low.
REQ-017 resp_valid outside RD_WAIT SHALL be ignored.
REQ-018 miss_valid while busy SHALL be ignored.
REQ-019 The beat counter SHALL be log2(WORDS_PER_LINE) bits, and its increment SHALL not wrap within a line.
REQ-020 The engine SHALL add no idle cycles: each state transition fires in the same cycle its handshake completes.

Reset
REQ-021 On rst_n low, regardless of state, the FSM SHALL go to IDLE, beat=0, and line buffer and captured registers SHALL clear to 0.
REQ-022 Reset values SHALL be: miss_ready=1, busy=0, req_valid=0, resp_ready=0, fill_valid=0, and all data/address outputs 0.
REQ-023 Reset mid-operation SHALL abandon the transaction, with no further requests issued.

Structure
REQ-024 Package refill_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-025 The line buffer and counter SHALL be inline, with no sub-module. The block SHALL connect directly to the simple request side of the single-beat AXI master bridge.

Verification
REQ-026 Clean miss at 0x1004, req_ready=1, resp after 1 cycle -> four reads at 0x1000/04/08/0C, then fill_addr=0x1000 with the returned words in order.
REQ-027 Dirty miss with victim 0x2000, data {D,C,B,A} -> four writes of A,B,C,D to 0x2000..0x200C with wstrb=0xF, then reads of the fill line.
REQ-028 req_ready low for 3 cycles mid-writeback -> req_addr/req_wdata held stable, and no beat skipped or duplicated.
REQ-029 fill_ready low for 5 cycles -> fill_valid and fill_data held, miss_ready stays 0, and a second miss is not accepted.
REQ-030 rst_n asserted during RD_WAIT of beat 2 -> next cycle IDLE, all outputs at reset values, and a new miss completes normally.
